// File: rtl/volcado_mem_datos_sucios.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | volcado_mem_datos_sucios: scans data memory and streams dirty words as   |
// | (address, data) records over a valid/ready handshake.   Rev 1.0          |
// +--------------------------------------------------------------------------+
module volcado_mem_datos_sucios #(
  parameter  int RAM_DEPTH          = 1024,
  parameter  int RAM_WIDTH          = 32,
  localparam int CANT_BIT_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
  input  logic                          i_clk,
  input  logic                          i_soft_reset,
  input  logic                          i_start,
  output logic [CANT_BIT_RAM_DEPTH-1:0] o_addr,
  output logic                          o_ena,
  input  logic                          i_bit_sucio,
  input  logic [RAM_WIDTH-1:0]          i_data,
  output logic                          o_valid,
  output logic [CANT_BIT_RAM_DEPTH-1:0] o_addr_out,
  output logic [RAM_WIDTH-1:0]          o_data_out,
  input  logic                          i_ready,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [CANT_BIT_RAM_DEPTH:0]   o_count
);

  localparam logic [CANT_BIT_RAM_DEPTH-1:0] C_LAST_ADDR = CANT_BIT_RAM_DEPTH'(RAM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [CANT_BIT_RAM_DEPTH-1:0] r_addr;
  logic [CANT_BIT_RAM_DEPTH-1:0] r_addr_out;
  logic [RAM_WIDTH-1:0]          r_data_out;
  logic                          r_valid;
  logic                          r_done;
  logic [CANT_BIT_RAM_DEPTH:0]   r_count;
  logic                          w_last;
  logic                          w_ena;
  logic                          w_accept;

  always_ff @(posedge i_clk or negedge i_soft_reset) begin
    if (!i_soft_reset) r_state <= IDLE;
    else               r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ena        = 1'b0;
    w_accept     = 1'b0;
    w_last       = (r_addr == C_LAST_ADDR);
    case (r_state)
      IDLE: begin
        if (i_start) w_state_next = CHECK;
      end
      CHECK: begin
        if (i_bit_sucio) begin
          w_ena        = 1'b1;
          w_state_next = CAPTURE;
        end else if (w_last) begin
          w_state_next = DONE;
        end
      end
      CAPTURE: begin
        w_state_next = SEND;
      end
      SEND: begin
        if (r_valid && i_ready) begin
          w_accept     = 1'b1;
          w_state_next = w_last ? DONE : CHECK;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The last address is detected explicitly so the counter never wraps to 0.
  always_ff @(posedge i_clk or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      r_addr     <= '0;
      r_addr_out <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr  <= '0;
            r_count <= '0;
          end
        end
        CHECK: begin
          if (!i_bit_sucio && !w_last) r_addr <= r_addr + 1'b1;
        end
        CAPTURE: begin
          r_addr_out <= r_addr;
          r_data_out <= i_data;
          r_valid    <= 1'b1;
        end
        SEND: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_count <= r_count + 1'b1;
            if (!w_last) r_addr <= r_addr + 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_addr     = r_addr;
  assign o_ena      = w_ena;
  assign o_valid    = r_valid;
  assign o_addr_out = r_addr_out;
  assign o_data_out = r_data_out;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_volcado_mem_datos_sucios.sv
`default_nettype none
// Bench for volcado_mem_datos_sucios: random dirty maps, data and consumer
// stalls checked against a record queue and a cycle-budget model.
module tb_volcado_mem_datos_sucios;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int AW    = 3;

  typedef struct packed {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } rec_t;

  logic             clk;
  logic             rst_n;
  logic             i_start;
  logic [AW-1:0]    o_addr;
  logic             o_ena;
  logic             i_bit_sucio;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic [AW-1:0]    o_addr_out;
  logic [WIDTH-1:0] o_data_out;
  logic             i_ready;
  logic             o_busy;
  logic             o_done;
  logic [AW:0]      o_count;

  logic [DEPTH-1:0] dirty;
  logic [WIDTH-1:0] mem [DEPTH];

  int n_pass;
  int n_total;

  volcado_mem_datos_sucios #(
    .RAM_DEPTH(DEPTH),
    .RAM_WIDTH(WIDTH)
  ) dut (
    .i_clk       (clk),
    .i_soft_reset(rst_n),
    .i_start     (i_start),
    .o_addr      (o_addr),
    .o_ena       (o_ena),
    .i_bit_sucio (i_bit_sucio),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_addr_out  (o_addr_out),
    .o_data_out  (o_data_out),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_count     (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: combinational dirty lookup, synchronous memory read.
  assign i_bit_sucio = dirty[o_addr];
  always @(posedge clk) if (o_ena) i_data <= mem[o_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One complete dump. Expected records are every dirty address in ascending
  // order; o_done must appear DEPTH + 2*D + 1 + (total stall cycles) after start.
  task automatic run_scan(input int first_stall, input int max_stall, input bit poke_start);
    rec_t q[$];
    rec_t r;
    int   d, stall_sum, stall_left, ena_cnt, t, nrec;
    bit   in_rec, finished;
    for (int a = 0; a < DEPTH; a++) begin
      if (dirty[a]) begin
        r.a = AW'(a);
        r.d = mem[a];
        q.push_back(r);
      end
    end
    d = q.size();
    stall_sum = 0; stall_left = 0; ena_cnt = 0; nrec = 0;
    in_rec = 1'b0; finished = 1'b0;
    @(negedge clk); i_start = 1'b1; i_ready = 1'b1;
    @(negedge clk); i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
    t = 0;
    while (t < 400 && !finished) begin
      if (t > 0) @(negedge clk);
      i_start = poke_start && (t == 4);
      if (o_ena) ena_cnt++;
      if (o_valid) begin
        if (!in_rec) begin
          in_rec = 1'b1;
          if (nrec == 0 && first_stall >= 0) stall_left = first_stall;
          else stall_left = int'($urandom_range(0, max_stall));
          stall_sum += stall_left;
          nrec++;
          if (q.size() == 0) begin
            chk("extra_record", 64'd1, 64'd0);
            q.push_back('0);
          end
        end
        chk("rec_addr", 64'(o_addr_out), 64'(q[0].a));
        chk("rec_data", 64'(o_data_out), 64'(q[0].d));
        if (stall_left > 0) begin
          i_ready = 1'b0;
          stall_left--;
        end else begin
          i_ready = 1'b1;
          in_rec  = 1'b0;
          void'(q.pop_front());
        end
      end else begin
        i_ready = 1'($urandom_range(0, 1));
      end
      if (o_done) begin
        finished = 1'b1;
        chk("done_cycle", 64'(t), 64'(DEPTH + 2 * d + 1 + stall_sum));
        chk("final_count", 64'(o_count), 64'(d));
        chk("ena_pulses", 64'(ena_cnt), 64'(d));
        chk("records_left", 64'(q.size()), 64'd0);
      end
      t++;
    end
    if (!finished) chk("scan_timeout", 64'd0, 64'd1);
    i_start = 1'b0;
    @(negedge clk);
    chk("done_single", 64'(o_done), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("count_hold", 64'(o_count), 64'(d));
  endtask

  task automatic fill_mem_random();
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
  endtask

  initial begin
    int t;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; i_start = 1'b0; i_ready = 1'b0; dirty = '0;
    fill_mem_random();
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_ena", 64'(o_ena), 64'd0);
    chk("rst_addr_out", 64'(o_addr_out), 64'd0);
    chk("rst_data_out", 64'(o_data_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy0", 64'(o_busy), 64'd0);

    // All clean.
    dirty = '0;
    run_scan(-1, 0, 1'b0);

    // Dirty at 0, 3, 7 with known data, no stalls, then a 5-cycle first stall.
    dirty = 8'b1000_1001;
    mem[0] = 32'hA0; mem[3] = 32'hA3; mem[7] = 32'hA7;
    run_scan(0, 0, 1'b0);
    run_scan(5, 0, 1'b0);

    // Every address dirty.
    dirty = '1;
    fill_mem_random();
    run_scan(0, 0, 1'b0);

    // Second start request in the middle of a scan is ignored.
    dirty = 8'b0101_0110;
    run_scan(-1, 2, 1'b1);

    // Random dirty maps, data and stalls.
    for (int k = 0; k < 6; k++) begin
      dirty = DEPTH'($urandom);
      fill_mem_random();
      run_scan(-1, 3, 1'b0);
    end

    // Reset while stalled in SEND after two accepted records.
    dirty = '1;
    fill_mem_random();
    @(negedge clk); i_start = 1'b1; i_ready = 1'b1;
    @(negedge clk); i_start = 1'b0;
    t = 0;
    while (t < 100 && !(o_valid && o_count == 2)) begin
      if (o_count == 2) i_ready = 1'b0;
      @(negedge clk);
      t++;
    end
    i_ready = 1'b0;
    if (t >= 100) chk("reset_setup_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    chk("pre_rst_count", 64'(o_count), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_valid), 64'd0);
    chk("async_rst_busy", 64'(o_busy), 64'd0);
    chk("async_rst_count", 64'(o_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'(o_busy), 64'd0);
    dirty = DEPTH'($urandom) | 8'h01;
    fill_mem_random();
    run_scan(-1, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/volcado_mem_datos_sucios.md
Name: volcado_mem_datos_sucios

Overview:
Reader side of the data-memory dirty-bit tracker. On a debug-unit command it scans every data-memory address. For each address whose dirty bit is set, it reads the word and emits an (address, data) record over a valid/ready handshake to the debug/UART transmit path. Clean addresses are skipped. It sits between the data memory, the dirty-bit tracker and the debug unit, and is active only while the MIPS pipeline is halted.

Parameters:
RAM_DEPTH, 1024, number of data-memory entries; address width CANT_BIT_RAM_DEPTH = clogb2(RAM_DEPTH).
RAM_WIDTH, 32, data-memory word width in bits.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_soft_reset  input  1  asynchronous, active-low reset.
i_start  input  1  one-cycle request to start a dump; sampled only in IDLE.
o_addr  output  CANT_BIT_RAM_DEPTH  address driven to data memory and to the dirty-bit tracker.
o_ena  output  1  data-memory read enable; write enable is never driven by this block.
i_bit_sucio  input  1  dirty bit for o_addr, combinational, same cycle.
i_data  input  RAM_WIDTH  data-memory read data, valid one cycle after o_ena with o_addr.
o_valid  output  1  record available.
o_addr_out  output  CANT_BIT_RAM_DEPTH  address of the current record.
o_data_out  output  RAM_WIDTH  data of the current record.
i_ready  input  1  consumer accepts the record when o_valid&i_ready.
o_busy  output  1  high in every state except IDLE.
o_done  output  1  single-cycle pulse at end of scan.
o_count  output  CANT_BIT_RAM_DEPTH+1  number of records accepted in the current or last scan.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; o_addr=0, o_ena=0, o_valid=0, o_addr_out=0, o_data_out=0, o_busy=0, o_done=0, o_count=0. A reset mid-scan aborts immediately; no partial record survives.
- IDLE:
  - o_busy=0, o_valid=0.
  - On i_start=1: scan address=0, o_count=0, go to CHECK.
- CHECK:
  - o_addr = scan address.
  - If i_bit_sucio=1: assert o_ena in this cycle only, go to CAPTURE.
  - Else if address = RAM_DEPTH-1: go to DONE.
  - Else: address+1, stay in CHECK.
- CAPTURE:
  - Register i_data into o_data_out and the scan address into o_addr_out.
  - Set o_valid=1 from the next cycle; go to SEND.
- SEND:
  - o_valid=1; o_addr_out and o_data_out are held stable until the handshake.
  - On o_valid&i_ready: o_count+1 and o_valid drops the next cycle. Then go to DONE if address = RAM_DEPTH-1, else address+1 and go to CHECK.
  - Handshake completes in the first cycle that i_ready=1; there is no minimum stall.
- DONE:
  - o_done=1 for exactly one cycle; o_count holds its final value; go to IDLE.
  - o_count keeps its value in IDLE until the next i_start.
- Cycle budget with i_ready tied high: N clean addresses cost 1 cycle each; each dirty address costs 3 cycles (CHECK, CAPTURE, SEND). o_done rises RAM_DEPTH + 2*D + 1 cycles after the i_start sampling edge, where D is the number of dirty addresses.
- i_start while o_busy=1 is ignored; there is no restart and no queued request.
- The address counter never wraps. The last address is detected explicitly, so RAM_DEPTH-1 is never followed by a fetch of address 0.
- o_ena=1 only in CHECK cycles with i_bit_sucio=1. No memory write ever occurs.
- o_count is wide enough for RAM_DEPTH (all addresses dirty) without overflow.

Test Plan:
- RAM_DEPTH=8, no dirty bits, i_ready=1, i_start pulse -> no o_valid; o_done at cycle 9 after the start edge; o_count=0.
- RAM_DEPTH=8, dirty at 0, 3, 7 with data 0xA0, 0xA3, 0xA7, i_ready=1 -> three records (0,0xA0), (3,0xA3), (7,0xA7) in order; o_done at cycle 15; o_count=3; o_ena asserted exactly 3 times.
- Same setup, i_ready held 0 for 5 cycles at the first record -> o_valid, o_addr_out=0 and o_data_out=0xA0 stable for 6 cycles; scan resumes after the handshake; o_done delayed by 5 cycles.
- All 8 addresses dirty, i_ready=1 -> 8 records for addresses 0..7; o_count=8; o_done at cycle 25; no record for address 0 after address 7.
- i_start pulsed again during the scan -> ignored; exactly one o_done; o_count unaffected.
- i_soft_reset=0 asserted while in SEND -> o_valid, o_busy and o_count go to 0 asynchronously; a new i_start after release rescans from address 0.
